// File: rtl/i2c_slave_regfile.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : i2c_slave_regfile                                       |
// | Brief    : Oversampled I2C slave answering one 7-bit address, with |
// |            a byte-wide register file and auto-incrementing pointer |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module i2c_slave_regfile #(
  parameter logic [6:0] SLAVE_ADDR = 7'h22,
  parameter int         MEM_DEPTH  = 16,
  parameter int         PTR_W      = $clog2(MEM_DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_o,
  output logic             busy_o,
  output logic             wr_stb_o,
  output logic [PTR_W-1:0] wr_addr_o,
  output logic [7:0]       wr_data_o,
  output logic             rd_stb_o
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_PTR, ST_PTR_ACK,
    ST_WDATA, ST_WDATA_ACK, ST_RDATA, ST_RDATA_ACK, ST_IGNORE
  } state_t;

  logic             r_scl_s1, r_scl_s2, r_scl_d;
  logic             r_sda_s1, r_sda_s2, r_sda_d;
  logic             w_scl_rise, w_scl_fall, w_start, w_stop;

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic [PTR_W-1:0] r_ptr, w_ptr_nxt;
  logic             r_rw, w_rw_nxt;
  logic             r_sda, w_sda_nxt;
  logic             r_busy, w_busy_nxt;
  logic             w_wr_stb, w_rd_stb;
  logic [7:0]       w_byte, w_rd_byte;
  logic [7:0]       r_mem [MEM_DEPTH];

  // Two-flop synchronizers plus one delayed copy for edge detection; preset to the idle bus level
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      {r_scl_s1, r_scl_s2, r_scl_d} <= 3'b111;
      {r_sda_s1, r_sda_s2, r_sda_d} <= 3'b111;
    end else begin
      r_scl_s1 <= scl_i;
      r_scl_s2 <= r_scl_s1;
      r_scl_d  <= r_scl_s2;
      r_sda_s1 <= sda_i;
      r_sda_s2 <= r_sda_s1;
      r_sda_d  <= r_sda_s2;
    end
  end

  // START/STOP need SCL stable high on both samples, so an SDA edge that lands with an SCL edge counts as data
  assign w_scl_rise = r_scl_s2 & ~r_scl_d;
  assign w_scl_fall = ~r_scl_s2 & r_scl_d;
  assign w_start    = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
  assign w_stop     = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;

  assign w_byte    = {r_shift[6:0], r_sda_s2};
  assign w_rd_byte = r_mem[r_ptr];
  assign sda_o     = r_sda;
  assign busy_o    = r_busy;

  // Next-state and datapath decode; ACK states use bit_cnt==8 for the first SCL fall (drive ACK) and 0 for the second (release)
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_ptr_nxt     = r_ptr;
    w_rw_nxt      = r_rw;
    w_sda_nxt     = r_sda;
    w_busy_nxt    = r_busy;
    w_wr_stb      = 1'b0;
    w_rd_stb      = 1'b0;
    if (w_stop) begin
      w_state_nxt   = ST_IDLE;
      w_bit_cnt_nxt = 4'd0;
      w_sda_nxt     = 1'b1;
      w_busy_nxt    = 1'b0;
    end else if (w_start) begin
      w_state_nxt   = ST_ADDR;
      w_bit_cnt_nxt = 4'd0;
      w_sda_nxt     = 1'b1;
    end else begin
      case (r_state)
        ST_ADDR: if (w_scl_rise) begin
          w_shift_nxt   = w_byte;
          w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          if (r_bit_cnt == 4'd7) begin
            if (w_byte[7:1] == SLAVE_ADDR) begin
              w_state_nxt = ST_ADDR_ACK;
              w_busy_nxt  = 1'b1;
              w_rw_nxt    = w_byte[0];
            end else begin
              w_state_nxt = ST_IGNORE;
              w_busy_nxt  = 1'b0;
            end
          end
        end
        ST_PTR: if (w_scl_rise) begin
          w_shift_nxt   = w_byte;
          w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          if (r_bit_cnt == 4'd7) begin
            w_ptr_nxt   = w_byte[PTR_W-1:0];
            w_state_nxt = ST_PTR_ACK;
          end
        end
        ST_WDATA: if (w_scl_rise) begin
          w_shift_nxt   = w_byte;
          w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          if (r_bit_cnt == 4'd7) begin
            w_wr_stb    = 1'b1;
            w_ptr_nxt   = r_ptr + 1'b1;
            w_state_nxt = ST_WDATA_ACK;
          end
        end
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: if (w_scl_fall) begin
          if (r_bit_cnt == 4'd8) begin
            w_sda_nxt     = 1'b0;
            w_bit_cnt_nxt = 4'd0;
          end else if (r_state == ST_ADDR_ACK && r_rw) begin
            w_shift_nxt = w_rd_byte;
            w_sda_nxt   = w_rd_byte[7];
            w_rd_stb    = 1'b1;
            w_state_nxt = ST_RDATA;
          end else begin
            w_sda_nxt   = 1'b1;
            w_state_nxt = (r_state == ST_ADDR_ACK) ? ST_PTR : ST_WDATA;
          end
        end
        ST_RDATA: begin
          if (w_scl_rise) begin
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          end else if (w_scl_fall) begin
            if (r_bit_cnt == 4'd8) begin
              w_sda_nxt   = 1'b1;
              w_state_nxt = ST_RDATA_ACK;
            end else if (r_bit_cnt != 4'd0) begin
              w_sda_nxt   = r_shift[6];
              w_shift_nxt = {r_shift[6:0], 1'b0};
            end
          end
        end
        ST_RDATA_ACK: begin
          if (w_scl_rise && r_bit_cnt == 4'd8) begin
            if (!r_sda_s2) begin
              w_ptr_nxt     = r_ptr + 1'b1;
              w_bit_cnt_nxt = 4'd0;
            end else begin
              w_state_nxt = ST_IGNORE;
              w_busy_nxt  = 1'b0;
            end
          end else if (w_scl_fall && r_bit_cnt == 4'd0) begin
            w_shift_nxt = w_rd_byte;
            w_sda_nxt   = w_rd_byte[7];
            w_rd_stb    = 1'b1;
            w_state_nxt = ST_RDATA;
          end
        end
        default: ;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Datapath and output registers; wr_addr/wr_data hold the last write between strobes
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_bit_cnt <= 4'd0;
      r_shift   <= 8'h00;
      r_ptr     <= '0;
      r_rw      <= 1'b0;
      r_sda     <= 1'b1;
      r_busy    <= 1'b0;
      wr_stb_o  <= 1'b0;
      rd_stb_o  <= 1'b0;
      wr_addr_o <= '0;
      wr_data_o <= 8'h00;
    end else begin
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_ptr     <= w_ptr_nxt;
      r_rw      <= w_rw_nxt;
      r_sda     <= w_sda_nxt;
      r_busy    <= w_busy_nxt;
      wr_stb_o  <= w_wr_stb;
      rd_stb_o  <= w_rd_stb;
      if (w_wr_stb) begin
        wr_addr_o <= r_ptr;
        wr_data_o <= w_byte;
      end
    end
  end

  // Register file, cleared by reset, written on each completed write byte
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < MEM_DEPTH; i++) r_mem[i] <= 8'h00;
    end else if (w_wr_stb) begin
      r_mem[r_ptr] <= w_byte;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_regfile.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_i2c_slave_regfile                                    |
// | Brief    : Bus-level bench for i2c_slave_regfile: bit-banged master|
// |            with write-strobe and read-data scoreboards             |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module tb_i2c_slave_regfile;

  localparam int Q = 8;  // quarter SCL period in clk cycles

  logic       clk;
  logic       rst_n;
  logic       scl;
  logic       sda_m;
  wire        sda_bus;
  logic       sda_o;
  logic       busy_o;
  logic       wr_stb_o;
  logic [3:0] wr_addr_o;
  logic [7:0] wr_data_o;
  logic       rd_stb_o;

  int n_cmp = 0;
  int n_bad = 0;

  logic [11:0] exp_wr[$];
  logic [7:0]  exp_rd[$];
  logic [11:0] obs_wr [64];
  int          wr_evt_cnt  = 0;
  int          wr_rd_idx   = 0;
  int          rd_cnt      = 0;
  int          sda_low_cnt = 0;
  int          busy_cnt    = 0;

  assign sda_bus = sda_m & sda_o;

  i2c_slave_regfile #(.SLAVE_ADDR(7'h22), .MEM_DEPTH(16)) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .scl_i    (scl),
    .sda_i    (sda_bus),
    .sda_o    (sda_o),
    .busy_o   (busy_o),
    .wr_stb_o (wr_stb_o),
    .wr_addr_o(wr_addr_o),
    .wr_data_o(wr_data_o),
    .rd_stb_o (rd_stb_o)
  );

  initial clk = 1'b0;
  // 100 MHz system clock
  always #5 clk = ~clk;

  // Record DUT strobes and bus activity, sampled mid-cycle
  always @(negedge clk) begin
    if (wr_stb_o) begin
      obs_wr[wr_evt_cnt[5:0]] <= {wr_addr_o, wr_data_o};
      wr_evt_cnt <= wr_evt_cnt + 1;
    end
    if (rd_stb_o) rd_cnt <= rd_cnt + 1;
    if (!sda_o)   sda_low_cnt <= sda_low_cnt + 1;
    if (busy_o)   busy_cnt <= busy_cnt + 1;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic xfer_bit(input logic v, output logic r);
    sda_m = v;  wait_clk(Q);
    scl   = 1'b1; wait_clk(Q);
    r     = sda_bus; wait_clk(Q);
    scl   = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_start;
    sda_m = 1'b1; wait_clk(Q);
    scl   = 1'b1; wait_clk(Q);
    sda_m = 1'b0; wait_clk(Q);
    scl   = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_stop;
    sda_m = 1'b0; wait_clk(Q);
    scl   = 1'b1; wait_clk(Q);
    sda_m = 1'b1; wait_clk(Q);
  endtask

  task automatic send(input logic [7:0] b, input logic exp_ack, input string tag);
    logic r;
    logic a;
    for (int i = 7; i >= 0; i--) xfer_bit(b[i], r);
    xfer_bit(1'b1, a);
    chk(tag, 16'(a), 16'(exp_ack));
  endtask

  task automatic recv(input logic mack, input string tag);
    logic       r;
    logic [7:0] b;
    for (int i = 7; i >= 0; i--) begin
      xfer_bit(1'b1, r);
      b[i] = r;
    end
    xfer_bit(mack, r);
    chk(tag, 16'(b), 16'(exp_rd.pop_front()));
  endtask

  task automatic drain_wr(input string tag);
    wait_clk(4);
    while (wr_rd_idx < wr_evt_cnt && exp_wr.size() > 0) begin
      chk({tag, "_wr"}, 16'(obs_wr[wr_rd_idx[5:0]]), 16'(exp_wr.pop_front()));
      wr_rd_idx++;
    end
    chk({tag, "_extra_wr"}, 16'(wr_evt_cnt - wr_rd_idx), 16'd0);
    chk({tag, "_missing_wr"}, 16'(exp_wr.size()), 16'd0);
    wr_rd_idx = wr_evt_cnt;
    exp_wr.delete();
  endtask

  // Linear directed sequence
  initial begin
    int   rd0;
    int   s0;
    int   b0;
    logic r7, r6, r5, rx;

    rst_n = 1'b0; scl = 1'b1; sda_m = 1'b1;
    wait_clk(4);
    chk("rst_sda",     16'(sda_o),     16'd1);
    chk("rst_busy",    16'(busy_o),    16'd0);
    chk("rst_wr_stb",  16'(wr_stb_o),  16'd0);
    chk("rst_rd_stb",  16'(rd_stb_o),  16'd0);
    chk("rst_wr_addr", 16'(wr_addr_o), 16'd0);
    chk("rst_wr_data", 16'(wr_data_o), 16'd0);
    rst_n = 1'b1;
    wait_clk(4);

    // Write 0xA5, 0x5A starting at register 3
    exp_wr.push_back({4'h3, 8'hA5});
    exp_wr.push_back({4'h4, 8'h5A});
    i2c_start;
    send(8'h44, 1'b0, "w_addr_ack");
    chk("w_busy_on", 16'(busy_o), 16'd1);
    send(8'h03, 1'b0, "w_ptr_ack");
    send(8'hA5, 1'b0, "w_d0_ack");
    send(8'h5A, 1'b0, "w_d1_ack");
    i2c_stop;
    wait_clk(Q);
    chk("w_busy_off", 16'(busy_o), 16'd0);
    drain_wr("write");

    // Read back two bytes with repeated START
    rd0 = rd_cnt;
    i2c_start;
    send(8'h44, 1'b0, "r_addr_ack");
    send(8'h03, 1'b0, "r_ptr_ack");
    i2c_start;
    send(8'h45, 1'b0, "r_addr_rd_ack");
    exp_rd.push_back(8'hA5);
    exp_rd.push_back(8'h5A);
    recv(1'b0, "r_byte0");
    recv(1'b1, "r_byte1");
    chk("r_nack_sda",  16'(sda_o),  16'd1);
    chk("r_nack_busy", 16'(busy_o), 16'd0);
    i2c_stop;
    wait_clk(Q);
    chk("r_rd_stb_cnt", 16'(rd_cnt - rd0), 16'd2);

    // Wrong address: never acknowledged, bus and strobes untouched
    s0 = sda_low_cnt; b0 = busy_cnt; rd0 = rd_cnt;
    i2c_start;
    send(8'h50, 1'b1, "bad_addr_nack");
    i2c_stop;
    wait_clk(Q);
    chk("bad_sda_low",  16'(sda_low_cnt - s0), 16'd0);
    chk("bad_busy",     16'(busy_cnt - b0),    16'd0);
    chk("bad_rd_stb",   16'(rd_cnt - rd0),     16'd0);
    drain_wr("bad_addr");

    // Pointer wrap 15 -> 0 on write and read
    exp_wr.push_back({4'hF, 8'h11});
    exp_wr.push_back({4'h0, 8'h22});
    i2c_start;
    send(8'h44, 1'b0, "wrap_addr_ack");
    send(8'h0F, 1'b0, "wrap_ptr_ack");
    send(8'h11, 1'b0, "wrap_d0_ack");
    send(8'h22, 1'b0, "wrap_d1_ack");
    i2c_stop;
    drain_wr("wrap");
    i2c_start;
    send(8'h44, 1'b0, "wrap_r_addr_ack");
    send(8'h0F, 1'b0, "wrap_r_ptr_ack");
    i2c_start;
    send(8'h45, 1'b0, "wrap_r_rd_ack");
    exp_rd.push_back(8'h11);
    exp_rd.push_back(8'h22);
    recv(1'b0, "wrap_r_byte0");
    recv(1'b1, "wrap_r_byte1");
    i2c_stop;

    // Pointer 0x13 truncates to 3
    exp_wr.push_back({4'h3, 8'h7E});
    i2c_start;
    send(8'h44, 1'b0, "trunc_addr_ack");
    send(8'h13, 1'b0, "trunc_ptr_ack");
    send(8'h7E, 1'b0, "trunc_d_ack");
    i2c_stop;
    drain_wr("trunc");
    i2c_start;
    send(8'h44, 1'b0, "trunc_r_addr_ack");
    send(8'h03, 1'b0, "trunc_r_ptr_ack");
    i2c_start;
    send(8'h45, 1'b0, "trunc_r_rd_ack");
    exp_rd.push_back(8'h7E);
    recv(1'b1, "trunc_r_byte");
    i2c_stop;

    // STOP after 5 data bits: partial byte is dropped
    i2c_start;
    send(8'h44, 1'b0, "part_addr_ack");
    send(8'h05, 1'b0, "part_ptr_ack");
    xfer_bit(1'b1, rx); xfer_bit(1'b0, rx); xfer_bit(1'b1, rx);
    xfer_bit(1'b0, rx); xfer_bit(1'b1, rx);
    i2c_stop;
    drain_wr("partial");

    // Reset while the slave drives bit 4 (a 0) of reg[0]=0x22
    i2c_start;
    send(8'h44, 1'b0, "rst_addr_ack");
    send(8'h00, 1'b0, "rst_ptr_ack");
    i2c_start;
    send(8'h45, 1'b0, "rst_rd_ack");
    xfer_bit(1'b1, r7); xfer_bit(1'b1, r6); xfer_bit(1'b1, r5);
    chk("rst_pre_bits", 16'({r7, r6, r5}), 16'h0001);
    chk("rst_pre_sda",  16'(sda_o), 16'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_async_sda",  16'(sda_o),  16'd1);
    chk("rst_async_busy", 16'(busy_o), 16'd0);
    wait_clk(2);
    scl = 1'b1; sda_m = 1'b1;
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(Q);
    i2c_start;
    send(8'h44, 1'b0, "post_rst_addr_ack");
    send(8'h03, 1'b0, "post_rst_ptr_ack");
    i2c_start;
    send(8'h45, 1'b0, "post_rst_rd_ack");
    exp_rd.push_back(8'h00);
    recv(1'b1, "post_rst_reg3");
    i2c_stop;
    drain_wr("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
